fetch_unit_nway: RTL and testbench

- Parametrised successor to the single-cycle WAY-wide fetch stage.
- Issues WAY-wide I-cache requests through a valid/ready handshake with one request outstanding.
- Predecodes each returned group, queries the branch predictor for the first control-flow instruction, and truncates the group after it.
- Buffers fetched instructions in a circular fetch queue that decode drains at a variable rate; squashes in-flight responses on a backend redirect.

---
 rtl/fetch_unit_nway.sv | 200 ++++++++++++++++++++
 tb/tb_fetch_unit_nway.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit_nway.sv
// rtl/fetch_unit_nway.sv - WAY-wide fetch stage: I-cache handshake, predecode, branch lookup, circular fetch queue (optional FETCH_PERF_EN counters)
module fetch_unit_nway #(
  parameter int          WAY      = 3,
  parameter int          FQ_DEPTH = 8,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            flush,
  input  logic [31:0]                     flush_pc,
  output logic                            pred_lookup_valid,
  output logic [31:0]                     pred_lookup_pc,
  input  logic                            pred_taken,
  input  logic [31:0]                     pred_target,
  output logic                            ic_req_valid,
  input  logic                            ic_req_ready,
  output logic [31:0]                     ic_req_pc,
  input  logic                            ic_rsp_valid,
  input  logic [32*WAY-1:0]               ic_rsp_data,
  input  logic [$clog2(WAY+1)-1:0]        deq_count,
  output logic [WAY-1:0]                  out_valid,
  output logic [32*WAY-1:0]               out_pc,
  output logic [32*WAY-1:0]               out_inst,
  output logic [WAY-1:0]                  out_taken,
  output logic [32*WAY-1:0]               out_target,
  output logic [$clog2(FQ_DEPTH+1)-1:0]   fq_count
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]                     perf_groups,
  output logic [31:0]                     perf_flush_drops,
  output logic [31:0]                     perf_fq_full_cycles
`endif
);

  localparam int CW = $clog2(WAY + 1);
  localparam int QW = $clog2(FQ_DEPTH + 1);
  localparam int PW = $clog2(FQ_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t state, state_next;
  logic [31:0] pc, pc_next;

  // Queue storage; entries beyond the occupancy are never observed, so no reset.
  logic [31:0]         q_pc     [FQ_DEPTH];
  logic [31:0]         q_inst   [FQ_DEPTH];
  logic [31:0]         q_target [FQ_DEPTH];
  logic [FQ_DEPTH-1:0] q_taken;
  logic [PW-1:0]       head, tail;
  logic [QW-1:0]       count;

  logic [QW-1:0] free_slots;
  logic          rsp_take;
  logic [WAY-1:0] is_cti;
  logic          found;
  logic [CW-1:0] br_idx;
  logic [CW-1:0] grp_len;
  logic [CW-1:0] enq_count;
  logic          take_branch;

  assign free_slots  = QW'(FQ_DEPTH) - count;
  // A response is only useful in WAIT; a same-cycle flush discards it.
  assign rsp_take    = (state == WAIT) && ic_rsp_valid && !flush;
  assign take_branch = found && pred_taken;
  assign enq_count   = rsp_take ? grp_len : '0;
  assign ic_req_pc   = pc;
  assign fq_count    = count;

  assign pred_lookup_valid = rsp_take && found;
  assign pred_lookup_pc    = pc + (32'(br_idx) << 2);

  // Predecode every slot for conditional branches, JAL and JALR.
  always_comb begin
    is_cti = '0;
    for (int i = 0; i < WAY; i++) begin
      case (ic_rsp_data[32*i +: 7])
        7'b1100011: is_cti[i] = (ic_rsp_data[32*i+12 +: 3] != 3'b010) &&
                                (ic_rsp_data[32*i+12 +: 3] != 3'b011);
        7'b1101111: is_cti[i] = 1'b1;
        7'b1100111: is_cti[i] = (ic_rsp_data[32*i+12 +: 3] == 3'b000);
        default:    is_cti[i] = 1'b0;
      endcase
    end
  end

  // Locate the lowest control-flow slot; the group is truncated right after it.
  always_comb begin
    found  = 1'b0;
    br_idx = '0;
    for (int i = WAY - 1; i >= 0; i--) begin
      if (is_cti[i]) begin
        found  = 1'b1;
        br_idx = CW'(i);
      end
    end
    grp_len = found ? (br_idx + CW'(1)) : CW'(WAY);
  end

  // Next-state, request strobe and next PC; flush overrides everything.
  always_comb begin
    state_next   = state;
    pc_next      = pc;
    ic_req_valid = 1'b0;
    case (state)
      IDLE: begin
        ic_req_valid = !reset && !flush && (free_slots >= QW'(WAY));
        if (ic_req_valid && ic_req_ready) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (flush) begin
          state_next = ic_rsp_valid ? IDLE : DROP;
        end else if (ic_rsp_valid) begin
          state_next = IDLE;
          pc_next    = take_branch ? pred_target : pc + (32'(grp_len) << 2);
        end
      end
      DROP: begin
        // A response arriving together with another flush still retires the
        // outstanding request, otherwise DROP would wait forever.
        if (ic_rsp_valid) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (flush) begin
      pc_next = flush_pc;
    end
  end

  // State and PC registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  // Queue pointers and occupancy; enqueue and dequeue may coincide.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(deq_count);
      tail  <= tail + PW'(enq_count);
      count <= count + QW'(enq_count) - QW'(deq_count);
    end
  end

  // Write the accepted slots of a response group at the tail.
  always_ff @(posedge clock) begin
    if (rsp_take) begin
      for (int i = 0; i < WAY; i++) begin
        if (CW'(i) < grp_len) begin
          q_pc[tail + PW'(i)]     <= pc + 32'(4 * i);
          q_inst[tail + PW'(i)]   <= ic_rsp_data[32*i +: 32];
          q_taken[tail + PW'(i)]  <= take_branch && (CW'(i) == br_idx);
          q_target[tail + PW'(i)] <= (take_branch && (CW'(i) == br_idx)) ? pred_target : 32'h0;
        end
      end
    end
  end

  // Present the oldest WAY entries, head-relative.
  always_comb begin
    for (int i = 0; i < WAY; i++) begin
      out_valid[i]          = QW'(i) < count;
      out_pc[32*i +: 32]     = q_pc[head + PW'(i)];
      out_inst[32*i +: 32]   = q_inst[head + PW'(i)];
      out_taken[i]          = q_taken[head + PW'(i)];
      out_target[32*i +: 32] = q_target[head + PW'(i)];
    end
  end

`ifdef FETCH_PERF_EN
  logic rsp_drop;
  assign rsp_drop = ic_rsp_valid && ((state == DROP) || ((state == WAIT) && flush));

  // Event counters: enqueued groups, discarded responses, queue-full stalls.
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_groups         <= '0;
      perf_flush_drops    <= '0;
      perf_fq_full_cycles <= '0;
    end else begin
      if (rsp_take) perf_groups <= perf_groups + 32'd1;
      if (rsp_drop) perf_flush_drops <= perf_flush_drops + 32'd1;
      if ((state == IDLE) && (free_slots < QW'(WAY))) perf_fq_full_cycles <= perf_fq_full_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit_nway.sv
// tb/tb_fetch_unit_nway.sv - self-checking bench for fetch_unit_nway with a queue-level reference model
module tb_fetch_unit_nway;
  localparam int WAY = 3;
  localparam int FQ_DEPTH = 8;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] ADD = 32'h00000033;
  localparam logic [31:0] BEQ = 32'h00000063;
  localparam logic [31:0] JAL = 32'h0000006f;

  logic clock, reset, flush;
  logic [31:0] flush_pc;
  logic pred_lookup_valid;
  logic [31:0] pred_lookup_pc;
  logic pred_taken;
  logic [31:0] pred_target;
  logic ic_req_valid, ic_req_ready;
  logic [31:0] ic_req_pc;
  logic ic_rsp_valid = 1'b0;
  logic [32*WAY-1:0] ic_rsp_data = '0;
  logic [1:0] deq_count = 2'd0;
  logic [WAY-1:0] out_valid, out_taken;
  logic [32*WAY-1:0] out_pc, out_inst, out_target;
  logic [3:0] fq_count;

  fetch_unit_nway #(.WAY(WAY), .FQ_DEPTH(FQ_DEPTH), .RESET_PC(32'h0)) dut (
    .clock(clock), .reset(reset), .flush(flush), .flush_pc(flush_pc),
    .pred_lookup_valid(pred_lookup_valid), .pred_lookup_pc(pred_lookup_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_pc(ic_req_pc),
    .ic_rsp_valid(ic_rsp_valid), .ic_rsp_data(ic_rsp_data), .deq_count(deq_count),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
    .out_taken(out_taken), .out_target(out_target), .fq_count(fq_count)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        taken;
    logic [31:0] target;
  } ent_t;

  typedef struct {
    int          cnt;
    logic [31:0] pc0, pc1, pc2, tgt1;
    logic [2:0]  taken;
  } snap_t;

  ent_t        m_q[$];
  logic [31:0] m_pc;
  bit          m_out, m_stale, prev_enq;
  logic [31:0] hs_log[$];
  logic [31:0] lk_log[$];
  snap_t       snap_log[$];
  logic [31:0] mem [logic [31:0]];
  bit          pend;
  logic [31:0] pend_pc;
  int          pend_cnt;
  int          rsp_lat = 1;
  int          deq_want = 0;

  int          c_sz, c_idx, c_len, env_sz;
  bit          c_rv, c_take, c_found, c_tk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : NOP;
  endfunction

  function automatic bit is_cti(input logic [31:0] w);
    case (w[6:0])
      7'b1100011: return w[14:12] inside {3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
      7'b1101111: return 1'b1;
      7'b1100111: return w[14:12] == 3'b000;
      default:    return 1'b0;
    endcase
  endfunction

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // I-cache responder and decode-side drain, driven just after each rising edge.
  always @(posedge clock) begin
    #1;
    if (reset) begin
      pend = 1'b0;
      ic_rsp_valid = 1'b0;
    end else if (pend) begin
      pend_cnt--;
      if (pend_cnt <= 0) begin
        ic_rsp_valid = 1'b1;
        for (int i = 0; i < WAY; i++) ic_rsp_data[32*i +: 32] = mem_word(pend_pc + 32'(4 * i));
        pend = 1'b0;
      end else begin
        ic_rsp_valid = 1'b0;
      end
    end else begin
      ic_rsp_valid = 1'b0;
    end
    env_sz = m_q.size();
    deq_count = (deq_want < env_sz) ? 2'(deq_want) : 2'(env_sz);
  end

  // Per-cycle comparison against the queue-level model, then model advance.
  always @(negedge clock) begin
    if (reset) begin
      chk("rst_req_valid", 32'(ic_req_valid), 32'd0);
      chk("rst_lookup_valid", 32'(pred_lookup_valid), 32'd0);
      chk("rst_fq_count", 32'(fq_count), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      m_q.delete();
      m_pc = 32'h0;
      m_out = 1'b0;
      m_stale = 1'b0;
      prev_enq = 1'b0;
      pend = 1'b0;
    end else begin
      c_sz = m_q.size();
      chk("fq_count", 32'(fq_count), 32'(c_sz));
      for (int i = 0; i < WAY; i++) begin
        chk("out_valid", 32'(out_valid[i]), 32'(i < c_sz));
        if (i < c_sz) begin
          chk("out_pc", out_pc[32*i +: 32], m_q[i].pc);
          chk("out_inst", out_inst[32*i +: 32], m_q[i].inst);
          chk("out_taken", 32'(out_taken[i]), 32'(m_q[i].taken));
          chk("out_target", out_target[32*i +: 32], m_q[i].target);
        end
      end
      c_rv = !m_out && !flush && (FQ_DEPTH - c_sz >= WAY);
      chk("ic_req_valid", 32'(ic_req_valid), 32'(c_rv));
      if (c_rv) chk("ic_req_pc", ic_req_pc, m_pc);
      c_take = m_out && !m_stale && ic_rsp_valid && !flush;
      c_found = 1'b0;
      c_idx = 0;
      for (int i = WAY - 1; i >= 0; i--) begin
        if (is_cti(ic_rsp_data[32*i +: 32])) begin
          c_found = 1'b1;
          c_idx = i;
        end
      end
      c_len = c_found ? c_idx + 1 : WAY;
      chk("pred_lookup_valid", 32'(pred_lookup_valid), 32'(c_take && c_found));
      if (c_take && c_found) begin
        chk("pred_lookup_pc", pred_lookup_pc, m_pc + 32'(4 * c_idx));
        lk_log.push_back(pred_lookup_pc);
      end
      if (prev_enq) begin
        snap_log.push_back('{cnt: int'(fq_count), pc0: out_pc[31:0], pc1: out_pc[63:32],
                             pc2: out_pc[95:64], tgt1: out_target[63:32],
                             taken: out_taken & out_valid});
      end
      if (ic_req_valid && ic_req_ready) begin
        hs_log.push_back(ic_req_pc);
        pend = 1'b1;
        pend_pc = ic_req_pc;
        pend_cnt = rsp_lat;
      end
      prev_enq = 1'b0;
      if (flush) begin
        m_q.delete();
        m_pc = flush_pc;
        if (m_out) begin
          if (ic_rsp_valid) begin
            m_out = 1'b0;
            m_stale = 1'b0;
          end else begin
            m_stale = 1'b1;
          end
        end
      end else begin
        for (int i = 0; i < int'(deq_count); i++) void'(m_q.pop_front());
        if (m_out && ic_rsp_valid) begin
          if (!m_stale) begin
            for (int i = 0; i < c_len; i++) begin
              c_tk = c_found && (i == c_idx) && pred_taken;
              m_q.push_back('{pc: m_pc + 32'(4 * i), inst: ic_rsp_data[32*i +: 32],
                              taken: c_tk, target: c_tk ? pred_target : 32'h0});
            end
            m_pc = (c_found && pred_taken) ? pred_target : m_pc + 32'(4 * c_len);
            prev_enq = 1'b1;
          end
          m_out = 1'b0;
          m_stale = 1'b0;
        end else if (c_rv && ic_req_ready) begin
          m_out = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic wait_hs(input int n);
    int b = 0;
    while (hs_log.size() < n && b < 60) begin
      tick();
      b++;
    end
    chk("wait_handshakes", 32'(hs_log.size()), 32'(n));
  endtask

  task automatic quiesce(input logic [31:0] new_pc);
    int b = 0;
    ic_req_ready = 1'b0;
    while (m_out && b < 40) begin
      tick();
      b++;
    end
    chk("quiesce_idle", 32'(m_out), 32'd0);
    flush = 1'b1;
    flush_pc = new_pc;
    tick();
    flush = 1'b0;
    hs_log.delete();
    lk_log.delete();
    snap_log.delete();
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    flush_pc = 32'h0;
    pred_taken = 1'b0;
    pred_target = 32'h0;
    ic_req_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("hold_no_handshake", 32'(hs_log.size()), 32'd0);
    chk("hold_req_valid", 32'(ic_req_valid), 32'd1);
    chk("hold_req_pc", ic_req_pc, 32'h0);

    // Straight-line code, full-rate drain.
    deq_want = 3;
    rsp_lat = 1;
    ic_req_ready = 1'b1;
    wait_hs(3);
    chk("t1_req0", hs_log[0], 32'd0);
    chk("t1_req1", hs_log[1], 32'd12);
    chk("t1_req2", hs_log[2], 32'd24);
    chk("t1_cnt", 32'(snap_log[0].cnt), 32'd3);
    chk("t1_pc0", snap_log[0].pc0, 32'd0);
    chk("t1_pc1", snap_log[0].pc1, 32'd4);
    chk("t1_pc2", snap_log[0].pc2, 32'd8);

    // {ADD, BEQ, ADD} predicted taken to 0x100.
    mem.delete();
    mem[32'h0] = ADD;
    mem[32'h4] = BEQ;
    mem[32'h8] = ADD;
    pred_taken = 1'b1;
    pred_target = 32'h100;
    quiesce(32'h0);
    ic_req_ready = 1'b1;
    wait_hs(2);
    chk("t2_req0", hs_log[0], 32'h0);
    chk("t2_lookup", lk_log[0], 32'h4);
    chk("t2_next_req", hs_log[1], 32'h100);
    chk("t2_cnt", 32'(snap_log[0].cnt), 32'd2);
    chk("t2_pc1", snap_log[0].pc1, 32'h4);
    chk("t2_taken", 32'(snap_log[0].taken), 32'b010);
    chk("t2_target", snap_log[0].tgt1, 32'h100);

    // Same group predicted not taken.
    pred_taken = 1'b0;
    quiesce(32'h0);
    ic_req_ready = 1'b1;
    wait_hs(2);
    chk("t3_lookup", lk_log[0], 32'h4);
    chk("t3_next_req", hs_log[1], 32'h8);
    chk("t3_cnt", 32'(snap_log[0].cnt), 32'd2);
    chk("t3_taken", 32'(snap_log[0].taken), 32'b000);
    chk("t3_target", snap_log[0].tgt1, 32'h0);

    // No drain: issue stops once fewer than WAY slots are free.
    mem.delete();
    deq_want = 0;
    quiesce(32'h0);
    ic_req_ready = 1'b1;
    wait_hs(2);
    repeat (8) tick();
    chk("t4_fq_six", 32'(fq_count), 32'd6);
    chk("t4_stalled", 32'(ic_req_valid), 32'd0);
    chk("t4_no_more_req", 32'(hs_log.size()), 32'd2);
    deq_want = 1;
    tick();
    deq_want = 0;
    wait_hs(3);
    repeat (4) tick();
    chk("t4_resume_pc", hs_log[2], 32'd24);
    chk("t4_fq_full", 32'(fq_count), 32'd8);
    chk("t4_full_stall", 32'(ic_req_valid), 32'd0);

    // Flush while waiting; the late response must be discarded.
    quiesce(32'h0);
    rsp_lat = 3;
    ic_req_ready = 1'b1;
    wait_hs(1);
    flush = 1'b1;
    flush_pc = 32'h200;
    tick();
    flush = 1'b0;
    wait_hs(2);
    chk("t5_redirect_req", hs_log[1], 32'h200);
    chk("t5_fq_empty", 32'(fq_count), 32'd0);
    chk("t5_no_enqueue", 32'(snap_log.size()), 32'd0);
    chk("t5_no_lookup", 32'(lk_log.size()), 32'd0);

    // Flush coinciding with a response while 4 entries are queued.
    quiesce(32'h0);
    rsp_lat = 1;
    mem.delete();
    mem[32'h0] = JAL;
    ic_req_ready = 1'b1;
    wait_hs(3);
    chk("t6_rsp_now", 32'(ic_rsp_valid), 32'd1);
    chk("t6_fq_four", 32'(fq_count), 32'd4);
    flush = 1'b1;
    flush_pc = 32'h300;
    tick();
    flush = 1'b0;
    chk("t6_fq_cleared", 32'(fq_count), 32'd0);
    wait_hs(4);
    chk("t6_req1", hs_log[1], 32'h4);
    chk("t6_req2", hs_log[2], 32'h10);
    chk("t6_redirect_req", hs_log[3], 32'h300);
    chk("t6_jal_lookup", lk_log[0], 32'h0);
    chk("t6_groups", 32'(snap_log.size()), 32'd2);

    ic_req_ready = 1'b0;
    repeat (4) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
